// File: rtl/seg_display_driver.sv
// Time-multiplexed 4-digit common-anode 7-segment driver: refresh scan with anti-ghost blanking, blink timer, BCD decode.
// Optional build macro LEADING_ZERO_BLANK_EN suppresses a leading zero on digit3 while it is not being edited.
module seg_display_driver #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 16,
  parameter int BLINK_HALF   = 50000000
) (
  input  logic       MCLK,
  input  logic       RESET,
  input  logic [3:0] digit3,
  input  logic [3:0] digit2,
  input  logic [3:0] digit1,
  input  logic [3:0] digit0,
  input  logic [3:0] dp_en,
  input  logic       blink_en,
  input  logic [1:0] blink_loc,
  input  logic       blink_all,
  output logic [3:0] ANODE,
  output logic [6:0] SEG,
  output logic       DP
);

  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

  logic [RW-1:0] r_refresh_cnt;
  logic [1:0]    r_scan_idx;
  logic [BW-1:0] r_blink_cnt;
  logic          r_blink_phase;

  logic          w_refresh_wrap;
  logic          w_blink_active;
  logic          w_blink_wrap;
  logic          w_blank;
  logic          w_hide;
  logic [3:0]    w_digit;
  logic [6:0]    w_seg;
  logic [3:0]    w_anode;

  assign w_refresh_wrap = (r_refresh_cnt == RW'(REFRESH_DIV - 1));
  assign w_blink_active = blink_en | blink_all;
  assign w_blink_wrap   = (r_blink_cnt == BW'(BLINK_HALF - 1));
  assign w_blank        = (r_refresh_cnt < RW'(BLANK_CYCLES));

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_digit = digit0;
    case (r_scan_idx)
      2'd0: w_digit = digit0;
      2'd1: w_digit = digit1;
      2'd2: w_digit = digit2;
      2'd3: w_digit = digit3;
      default: w_digit = digit0;
    endcase
  end

  always_comb begin
    w_seg = 7'b0111111;
    case (w_digit)
      4'd0: w_seg = 7'b1000000;
      4'd1: w_seg = 7'b1111001;
      4'd2: w_seg = 7'b0100100;
      4'd3: w_seg = 7'b0110000;
      4'd4: w_seg = 7'b0011001;
      4'd5: w_seg = 7'b0010010;
      4'd6: w_seg = 7'b0000010;
      4'd7: w_seg = 7'b1111000;
      4'd8: w_seg = 7'b0000000;
      4'd9: w_seg = 7'b0010000;
      default: w_seg = 7'b0111111;
    endcase
  end

  // Hidden slots keep their anode high; blink_all outranks the single-digit blink.
  always_comb begin
    w_hide = 1'b0;
    if (!r_blink_phase) begin
      if (blink_all)
        w_hide = 1'b1;
      else if (blink_en && (r_scan_idx == blink_loc))
        w_hide = 1'b1;
    end
`ifdef LEADING_ZERO_BLANK_EN
    if ((r_scan_idx == 2'd3) && (digit3 == 4'd0) && !blink_en)
      w_hide = 1'b1;
`endif
  end

  always_comb begin
    w_anode = 4'b1111;
    if (!w_blank && !w_hide)
      w_anode = ~(4'b0001 << r_scan_idx);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge MCLK) begin
    if (RESET) begin
      r_refresh_cnt <= '0;
      r_scan_idx    <= 2'd0;
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b1;
      ANODE         <= 4'b1111;
      SEG           <= 7'b1111111;
      DP            <= 1'b1;
    end else begin
      if (w_refresh_wrap) begin
        r_refresh_cnt <= '0;
        r_scan_idx    <= r_scan_idx + 2'd1;
      end else begin
        r_refresh_cnt <= r_refresh_cnt + RW'(1);
      end

      if (!w_blink_active) begin
        r_blink_cnt   <= '0;
        r_blink_phase <= 1'b1;
      end else if (w_blink_wrap) begin
        r_blink_cnt   <= '0;
        r_blink_phase <= ~r_blink_phase;
      end else begin
        r_blink_cnt   <= r_blink_cnt + BW'(1);
      end

      ANODE <= w_anode;
      SEG   <= w_seg;
      DP    <= ~dp_en[r_scan_idx];
    end
  end

endmodule

// File: tb/tb_seg_display_driver.sv
// Scoreboard bench for seg_display_driver: an arithmetic model of absolute time predicts every registered output.
// Honours LEADING_ZERO_BLANK_EN when the build defines it.
module tb_seg_display_driver;

  localparam int RD = 8;
  localparam int BC = 2;
  localparam int BH = 64;

  logic       MCLK = 1'b0;
  logic       RESET;
  logic [3:0] digit3, digit2, digit1, digit0, dp_en;
  logic       blink_en, blink_all;
  logic [1:0] blink_loc;
  logic [3:0] ANODE;
  logic [6:0] SEG;
  logic       DP;

  seg_display_driver #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC), .BLINK_HALF(BH)) dut (
    .MCLK(MCLK), .RESET(RESET),
    .digit3(digit3), .digit2(digit2), .digit1(digit1), .digit0(digit0),
    .dp_en(dp_en), .blink_en(blink_en), .blink_loc(blink_loc), .blink_all(blink_all),
    .ANODE(ANODE), .SEG(SEG), .DP(DP)
  );

  always #5 MCLK = ~MCLK;

  typedef struct packed {
    logic [3:0] anode;
    logic [6:0] seg;
    logic       dp;
    logic       chk_seg;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   m_k      = 0;  // edges since reset release
  int   m_n      = 0;  // consecutive blink-enabled edges

  function automatic logic [6:0] seg_of(input logic [3:0] v);
    case (v)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction

  // Predict the outputs after the upcoming posedge, then step past it.
  task automatic tick();
    exp_t       e;
    int         cnt, slot;
    logic       visible;
    logic [3:0] dsel;
    if (RESET) begin
      e   = '{4'b1111, 7'b1111111, 1'b1, 1'b1};
      m_k = 0;
      m_n = 0;
    end else begin
      cnt     = m_k % RD;
      slot    = (m_k / RD) % 4;
      visible = (cnt >= BC);
      if (((m_n / BH) % 2) == 1) begin
        if (blink_all) visible = 1'b0;
        else if (blink_en && slot == int'(blink_loc)) visible = 1'b0;
      end
`ifdef LEADING_ZERO_BLANK_EN
      if (slot == 3 && digit3 == 4'd0 && !blink_en) visible = 1'b0;
`endif
      dsel = (slot == 0) ? digit0 : (slot == 1) ? digit1 : (slot == 2) ? digit2 : digit3;
      e.anode   = visible ? ~(4'b0001 << slot) : 4'b1111;
      e.seg     = seg_of(dsel);
      e.dp      = ~dp_en[slot];
      e.chk_seg = visible;
      m_k++;
      m_n = (blink_en || blink_all) ? m_n + 1 : 0;
    end
    exp_q.push_back(e);
    @(negedge MCLK);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check(input string name, input logic ok, input string got, input string want);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s cycle=%0d got %s expected %s", name, cyc, got, want);
    end
  endtask

  // Monitor: every cycle is an output event, compared against the oldest prediction.
  always @(posedge MCLK) begin
    exp_t e;
    #1;
    cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("anode", ANODE === e.anode, $sformatf("%b", ANODE), $sformatf("%b", e.anode));
      if (e.chk_seg) begin
        check("seg", SEG === e.seg, $sformatf("%b", SEG), $sformatf("%b", e.seg));
        check("dp", DP === e.dp, $sformatf("%b", DP), $sformatf("%b", e.dp));
      end else begin
        check("seg_known", !$isunknown({SEG, DP}), $sformatf("%b/%b", SEG, DP), "no X");
      end
    end
  end

  task automatic set_digits(input logic [3:0] d3, d2, d1, d0);
    digit3 = d3; digit2 = d2; digit1 = d1; digit0 = d0;
  endtask

  initial begin
    RESET = 1'b1;
    set_digits(4'd1, 4'd2, 4'd3, 4'd4);
    dp_en = 4'b0000; blink_en = 1'b0; blink_loc = 2'd0; blink_all = 1'b0;
    run(3);
    RESET = 1'b0;
    run(40);

    digit0 = 4'hC; dp_en = 4'b0001;
    run(40);

    set_digits(4'd8, 4'd8, 4'd8, 4'd8); dp_en = 4'b0000;
    blink_en = 1'b1; blink_loc = 2'd2;
    run(300);

    blink_all = 1'b1;
    run(300);

    blink_all = 1'b0;
    run(200);
    while (!(((m_k / RD) % 4) == 2 && (m_k % RD) >= 4)) tick();
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    run(160);

    blink_en = 1'b0;
    set_digits(4'd0, 4'd5, 4'd6, 4'd7);
    run(40);
    blink_en = 1'b1; blink_loc = 2'd0;
    run(40);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0)
        set_digits(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
      if ($urandom_range(0, 7) == 0) dp_en = 4'($urandom);
      if ($urandom_range(0, 15) == 0) blink_loc = 2'($urandom);
      if ($urandom_range(0, 199) == 0) blink_en = ~blink_en;
      if ($urandom_range(0, 299) == 0) blink_all = ~blink_all;
      RESET = ($urandom_range(0, 999) == 0);
      tick();
    end
    RESET = 1'b0;

    @(posedge MCLK); #2;
    check("drain", exp_q.size() == 0, $sformatf("%0d", exp_q.size()), "0");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
